// File: rtl/conv3x3_window_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_window_engine_if
// Description : Window / coefficient / filtered-pixel bundle for the 3x3
//               convolution engine.
//               master : window source + coefficient writer (drives inputs)
//               slave  : convolution engine (drives out_*)
//   in_pixels  [8:0][15:0] 3x3 RGB565 window, [0..2] top L/C/R, [3..5] mid,
//                          [6..8] bottom
//   in_valid               in_pixels holds a new window this cycle
//   coef_we/addr/data      coefficient write port (addr 0..8, signed data)
//   out_pixel              filtered RGB565 pixel
//   out_valid              out_pixel valid this cycle
//   out_eol                last column of a line (qualified by out_valid)
// Revision    : 1.0 - initial release
// ============================================================================
interface conv3x3_window_engine_if;
  logic [8:0][15:0] in_pixels;
  logic             in_valid;
  logic             coef_we;
  logic [3:0]       coef_addr;
  logic [7:0]       coef_data;
  logic [15:0]      out_pixel;
  logic             out_valid;
  logic             out_eol;

  modport master (
    output in_pixels, in_valid, coef_we, coef_addr, coef_data,
    input  out_pixel, out_valid, out_eol
  );

  modport slave (
    input  in_pixels, in_valid, coef_we, coef_addr, coef_data,
    output out_pixel, out_valid, out_eol
  );
endinterface
`default_nettype wire

// File: rtl/conv3x3_window_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_window_engine
// Description : Per-channel signed 3x3 convolution on RGB565 windows with
//               shift normalisation, clamp and repack. Fixed 3-cycle latency
//               (window sampled at edge N -> out_valid at edge N+3), valid-only,
//               no backpressure.
// Ports       : clk    - single clock
//               reset  - synchronous, active-high
//               bus    - conv3x3_window_engine_if.slave (window in, coefficient
//                        write port, filtered pixel out)
// Parameters  : LINE_WIDTH - windows per line (output column wrap)
//               SHIFT      - arithmetic right shift of each channel sum
// Option      : CONV_BORDER_ZERO_EN - when defined, columns 0 and LINE_WIDTH-1
//               output 0x0000 (their windows hold wrapped neighbours).
// Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_window_engine #(
  parameter int LINE_WIDTH = 640,
  parameter int SHIFT      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  conv3x3_window_engine_if.slave  bus
);

  localparam int                   NTAP       = 9;
  localparam int                   NCH        = 3;   // 0=R, 1=G, 2=B
  localparam int                   COL_W      = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [COL_W-1:0]     COL_LAST   = COL_W'(LINE_WIDTH - 1);
  localparam logic signed [7:0]    COEF_UNITY = 8'(1 << SHIFT);

  // Coefficient bank; identity kernel out of reset.
  logic signed [7:0]  coef_q [0:NTAP-1];

  logic signed [13:0] prod_d [0:NCH-1][0:NTAP-1];
  logic signed [13:0] prod_q [0:NCH-1][0:NTAP-1];
  logic signed [15:0] part_q [0:NCH-1][0:2];
  logic signed [17:0] tot_q  [0:NCH-1];
  logic               v1_q, v2_q, v3_q;

  logic [15:0]        out_pixel_q;
  logic               out_valid_q;
  logic               out_eol_q;
  logic [COL_W-1:0]   col_q;

  logic [15:0]        w_pix;
  logic               w_border;

  // The bank updates at the same edge that samples a window, so a window
  // presented together with a write still multiplies by the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAP; i++) begin
        coef_q[i] <= (i == 4) ? COEF_UNITY : 8'sd0;
      end
    end else if (bus.coef_we && (bus.coef_addr <= 4'd8)) begin
      coef_q[bus.coef_addr] <= bus.coef_data;
    end
  end

  // S1 multipliers: channels zero-extended to 7-bit signed, so the product
  // (|max| = 63*128) fits 14 bits.
  for (genvar t = 0; t < NTAP; t++) begin : g_tap
    logic signed [6:0] chan [0:NCH-1];
    assign chan[0] = {2'b00, bus.in_pixels[t][15:11]};
    assign chan[1] = {1'b0,  bus.in_pixels[t][10:5]};
    assign chan[2] = {2'b00, bus.in_pixels[t][4:0]};
    for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign prod_d[c][t] = 14'(chan[c]) * 14'(coef_q[t]);
    end
  end

  // Valid chain is the only reset pipeline state; data follows it.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= bus.in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      prod_q <= prod_d;
    end
    if (v1_q) begin
      for (int c = 0; c < NCH; c++) begin
        for (int r = 0; r < 3; r++) begin
          part_q[c][r] <= 16'(prod_q[c][3*r]) + 16'(prod_q[c][3*r+1])
                        + 16'(prod_q[c][3*r+2]);
        end
      end
    end
    if (v2_q) begin
      for (int c = 0; c < NCH; c++) begin
        tot_q[c] <= 18'(part_q[c][0]) + 18'(part_q[c][1]) + 18'(part_q[c][2]);
      end
    end
  end

  function automatic logic [5:0] clamp_ch(input logic signed [17:0] v,
                                          input logic [5:0]         maxv);
    logic signed [17:0] s;
    s = v >>> SHIFT;
    if (s < 0) begin
      return 6'd0;
    end else if (s > $signed({12'd0, maxv})) begin
      return maxv;
    end else begin
      return s[5:0];
    end
  endfunction

  assign w_pix = {5'(clamp_ch(tot_q[0], 6'd31)),
                  clamp_ch(tot_q[1], 6'd63),
                  5'(clamp_ch(tot_q[2], 6'd31))};

  // The output column counter tracks the column of the window now leaving
  // S3, since every accepted window produces exactly one output in order.
`ifdef CONV_BORDER_ZERO_EN
  assign w_border = (col_q == '0) || (col_q == COL_LAST);
`else
  assign w_border = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_pixel_q <= 16'h0000;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
      col_q       <= '0;
    end else begin
      out_valid_q <= v3_q;
      out_eol_q   <= v3_q && (col_q == COL_LAST);
      if (v3_q) begin
        out_pixel_q <= w_border ? 16'h0000 : w_pix;
        col_q       <= (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
      end
    end
  end

  assign bus.out_pixel = out_pixel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_eol   = out_eol_q;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_window_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_conv3x3_window_engine
// Description : Directed self-checking bench for conv3x3_window_engine with
//               hand-computed RGB565 results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv3x3_window_engine;

  localparam int LW = 640;
  localparam int SH = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  conv3x3_window_engine_if u_if ();

  conv3x3_window_engine #(
    .LINE_WIDTH (LW),
    .SHIFT      (SH)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  int n_vec  = 0;
  int n_err  = 0;
  int tb_col = 0;   // column of the next expected output

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int col, input logic [15:0] v);
`ifdef CONV_BORDER_ZERO_EN
    if (col == 0 || col == LW - 1) return 16'h0000;
`endif
    return v;
  endfunction

  task automatic idle();
    u_if.in_valid  = 1'b0;
    u_if.coef_we   = 1'b0;
    u_if.coef_addr = 4'd0;
    u_if.coef_data = 8'd0;
  endtask

  task automatic set_window(input logic [15:0] centre, input logic [15:0] other);
    for (int i = 0; i < 9; i++) u_if.in_pixels[i] = (i == 4) ? centre : other;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(negedge clk);
    reset  = 1'b0;
    tb_col = 0;
  endtask

  task automatic wr_coef(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    u_if.coef_we   = 1'b1;
    u_if.coef_addr = a;
    u_if.coef_data = d;
    @(negedge clk);
    u_if.coef_we   = 1'b0;
  endtask

  task automatic set_kernel(input logic [7:0] centre, input logic [7:0] other);
    for (int i = 0; i < 9; i++) wr_coef(4'(i), (i == 4) ? centre : other);
  endtask

  // One isolated window: checks latency, value, eol and hold afterwards.
  task automatic run_single(input string tag, input logic [15:0] centre,
                            input logic [15:0] other, input logic [15:0] exp);
    logic [2:0]  seen;
    logic [15:0] pix;
    logic [15:0] want;
    logic        eol;
    @(negedge clk);
    set_window(centre, other);
    u_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_if.in_valid = 1'b0;
    seen = '0;
    pix  = '0;
    eol  = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      seen[k-1] = u_if.out_valid;
      if (k == 3) begin
        pix = u_if.out_pixel;
        eol = u_if.out_eol;
      end
    end
    want = exp_pix(tb_col, exp);
    check({tag, " latency"}, 32'(seen), 32'b100);
    check({tag, " pixel"}, 32'(pix), 32'(want));
    check({tag, " eol"}, 32'(eol), 32'(tb_col == LW - 1));
    tb_col = (tb_col + 1) % LW;
    @(posedge clk);
    #1;
    check({tag, " hold"}, {15'd0, u_if.out_valid, u_if.out_pixel}, {16'd0, want});
  endtask

  // Wait (bounded) for the next output and check its value.
  task automatic grab(input string tag, input logic [15:0] exp);
    int cyc = 0;
    while (cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
      if (u_if.out_valid) break;
    end
    check({tag, " valid"}, 32'(u_if.out_valid), 32'd1);
    check({tag, " pixel"}, 32'(u_if.out_pixel), 32'(exp_pix(tb_col, exp)));
    tb_col = (tb_col + 1) % LW;
  endtask

  // Back-to-back stream of all-0xFFFF windows under the identity kernel.
  task automatic stream(input string tag, input int n);
    int outs = 0, eols = 0, bad_eol = 0, bad_pix = 0;
    int first_c = 0, last_c = 0, cyc = 0;
    set_window(16'hFFFF, 16'hFFFF);
    fork
      begin
        @(negedge clk);
        u_if.in_valid = 1'b1;
        repeat (n) @(negedge clk);
        u_if.in_valid = 1'b0;
      end
      begin
        while (outs < n && cyc < n + 20) begin
          @(posedge clk);
          #1;
          cyc++;
          if (u_if.out_valid) begin
            outs++;
            if (outs == 1) first_c = cyc;
            last_c = cyc;
            if (u_if.out_eol !== (tb_col == LW - 1)) bad_eol++;
            if (u_if.out_eol) eols++;
            if (u_if.out_pixel !== exp_pix(tb_col, 16'hFFFF)) bad_pix++;
            tb_col = (tb_col + 1) % LW;
          end
        end
      end
    join
    check({tag, " count"}, 32'(outs), 32'(n));
    check({tag, " contiguous"}, 32'(last_c - first_c), 32'(n - 1));
    check({tag, " eol count"}, 32'(eols), 32'(n / LW));
    check({tag, " eol position"}, 32'(bad_eol), 32'd0);
    check({tag, " pixel errors"}, 32'(bad_pix), 32'd0);
  endtask

  initial begin
    logic [3:0] vseen;
    reset = 1'b1;
    idle();
    set_window(16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset out_valid", 32'(u_if.out_valid), 32'd0);
    check("reset out_pixel", 32'(u_if.out_pixel), 32'd0);
    check("reset out_eol",   32'(u_if.out_eol),   32'd0);

    // Identity kernel: R=31*16>>4=31, B=31 -> 0xF81F
    run_single("identity", 16'hF81F, 16'h0000, 16'hF81F);

    // All ones: R=279>>4=17, G=567>>4=35, B=17 -> 0x8C71
    set_kernel(8'd1, 8'd1);
    run_single("ones", 16'hFFFF, 16'hFFFF, 16'h8C71);

    // Negative result clamps to 0
    set_kernel(8'hF0, 8'd0);
    run_single("clamp low", 16'hFFFF, 16'hFFFF, 16'h0000);

    // Large positive saturates; small input R=127>>4=7, G=254>>4=15 -> 0x39E7
    set_kernel(8'd127, 8'd0);
    run_single("clamp high", 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_single("coef127", 16'h0841, 16'h0841, 16'h39E7);

    // Write coinciding with a window: old kernel for it, new (centre 8) for
    // the next. centre 8: R=248>>4=15, G=504>>4=31, B=15 -> 0x7BEF
    do_reset();
    @(negedge clk);
    set_window(16'hFFFF, 16'hFFFF);
    u_if.in_valid  = 1'b1;
    u_if.coef_we   = 1'b1;
    u_if.coef_addr = 4'd4;
    u_if.coef_data = 8'd8;
    @(negedge clk);
    u_if.coef_we   = 1'b0;
    @(negedge clk);
    u_if.in_valid  = 1'b0;
    grab("same-cycle old", 16'hFFFF);
    grab("same-cycle new", 16'h7BEF);

    // Out-of-range addresses must not touch the bank
    wr_coef(4'd9, 8'd127);
    wr_coef(4'd12, 8'd127);
    wr_coef(4'd15, 8'h80);
    run_single("ignored addr", 16'hFFFF, 16'hFFFF, 16'h7BEF);

    // Two full lines
    do_reset();
    stream("stream1280", 1280);

    // Reset with two windows in flight under a non-identity kernel
    wr_coef(4'd4, 8'd8);
    @(negedge clk);
    set_window(16'hFFFF, 16'hFFFF);
    u_if.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    u_if.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    tb_col = 0;
    vseen  = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      vseen[k] = u_if.out_valid;
    end
    check("midreset flushed", 32'(vseen), 32'd0);
    check("midreset pixel", 32'(u_if.out_pixel), 32'd0);
    stream("after reset", 640);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
